// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, opcode field, opcode constants and fetch FSM states
package fetch_pkg;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int OP_W    = 3;
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam logic [OP_W-1:0] OP_RTYPE = 3'b000;
  localparam logic [OP_W-1:0] OP_ADDI  = 3'b001;
  localparam logic [OP_W-1:0] OP_LW    = 3'b010;
  localparam logic [OP_W-1:0] OP_SW    = 3'b011;
  localparam logic [OP_W-1:0] OP_BEQ   = 3'b100;
  localparam logic [OP_W-1:0] OP_J     = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REDIRECT} state_t;
  function automatic logic [OP_W-1:0] op_of(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of DEPTH x W words with flush and occupancy count
// Ports: clk, rst_n (async active-low); i_flush clears all entries;
// i_push/i_wdata write the tail; i_pop retires the head; o_rdata is the head
// word straight from storage; o_count is occupancy; o_valid is non-empty.
module fetch_buffer #(
  parameter int DEPTH = 3,
  parameter int W     = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_pop,
  output logic [W-1:0]               o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_valid
);
  import fetch_pkg::*;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction
  assign w_push  = i_push && (r_count != CW'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign o_rdata = r_mem[r_rd];
  assign o_count = r_count;
  assign o_valid = r_count != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_wdata;
        r_wr        <= inc(r_wr);
      end
      if (w_pop) r_rd <= inc(r_rd);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, fetch FSM and credit-based issue into a small instruction buffer
// Ports: clk, rst_n (async active-low); fetch_en permits issue; redirect_valid/
// redirect_pc restart fetch; mem_addr/mem_read_en drive a synchronous-read
// memory returning mem_instr one cycle later; out_* is the buffer head with a
// valid/ready handshake, out_op being the opcode field of out_instr.
module instruction_fetch #(
  parameter int               ADDR_W   = fetch_pkg::ADDR_W,
  parameter int               INSTR_W  = fetch_pkg::INSTR_W,
  parameter int               DEPTH    = 3,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fetch_en,
  input  logic                      redirect_valid,
  input  logic [ADDR_W-1:0]         redirect_pc,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_read_en,
  input  logic [INSTR_W-1:0]        mem_instr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INSTR_W-1:0]        out_instr,
  output logic [ADDR_W-1:0]         out_pc,
  output logic [fetch_pkg::OP_W-1:0] out_op
);
  import fetch_pkg::*;
  localparam int CW = $clog2(DEPTH+1);
  state_t                      r_state, w_next;
  logic [ADDR_W-1:0]           r_pc, r_issued_pc;
  logic                        r_inflight, w_issue, w_push, w_pop;
  logic [CW-1:0]               w_count;
  logic [INSTR_W+ADDR_W-1:0]   w_head;
  // Credit uses registered count and inflight only; a same-cycle pop does not free a slot early.
  always_comb begin
    w_next  = redirect_valid ? S_REDIRECT : fetch_en ? S_RUN : S_IDLE;
    w_issue = (r_state == S_RUN) && !redirect_valid && (int'(w_count) + int'(r_inflight) < DEPTH);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_issued_pc <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      if (w_issue) r_issued_pc <= r_pc;
      r_pc <= redirect_valid ? redirect_pc : w_issue ? r_pc + 1'b1 : r_pc;
    end
  // The response to the previous cycle's issue is dropped if a redirect lands on its arrival.
  assign w_push      = r_inflight && !redirect_valid;
  assign w_pop       = out_valid && out_ready;
  assign mem_addr    = r_pc;
  assign mem_read_en = w_issue;
  assign out_instr   = w_head[ADDR_W +: INSTR_W];
  assign out_pc      = w_head[ADDR_W-1:0];
  assign out_op      = op_of(out_instr);
  fetch_buffer #(.DEPTH(DEPTH), .W(INSTR_W+ADDR_W)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_wdata ({mem_instr, r_issued_pc}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_valid (out_valid)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch with a synchronous-read memory model
module tb_instruction_fetch;
  logic        clk = 0, rst_n = 1, fetch_en = 0, redirect_valid = 0, out_ready = 0;
  logic [7:0]  redirect_pc = 0, mem_addr, out_pc;
  logic [15:0] mem_instr = 0, out_instr;
  logic [2:0]  out_op;
  logic        mem_read_en, out_valid;
  logic [15:0] mem [256];
  logic [15:0] img [9] = '{16'h0000, 16'h0801, 16'h1002, 16'h1803, 16'h2004,
                           16'h4004, 16'h6004, 16'h8004, 16'hA004};
  logic [23:0] exp_q [$];
  int total = 0, bad = 0, hs = 0;
  always #5 clk = ~clk;
  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
    .mem_instr(mem_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_op(out_op)
  );
  always @(posedge clk) if (mem_read_en) mem_instr <= mem[mem_addr];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_seq(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] p;
      p = start + 8'(i);
      exp_q.push_back({p, mem[p]});
    end
  endtask
  task automatic wait_valid(input string name, input int lim, input int want);
    int n;
    n = 0;
    while (!out_valid && n < lim) begin
      tick();
      n++;
    end
    chk(name, n, want);
  endtask
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_read_en"}, mem_read_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_instr"}, out_instr, 0);
    chk({tag, "_pc"}, out_pc, 0);
    chk({tag, "_op"}, out_op, 0);
  endtask
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      logic [23:0] e;
      hs++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got pc %0h instr %0h want nothing", out_pc, out_instr);
      end else begin
        e = exp_q.pop_front();
        chk("out_pc", out_pc, e[23:16]);
        chk("out_instr", out_instr, e[15:0]);
        chk("out_op", out_op, e[15:13]);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int iss, h0;
    for (int a = 0; a < 256; a++) begin
      logic [7:0] av;
      av = a[7:0];
      mem[a] = (a < 9) ? img[a] : {av, ~av};
    end
    #2 rst_n = 0;
    tick();
    tick();
    chk_reset_outs("rst");
    rst_n = 1;
    tick();
    // sequential stream from reset
    exp_q.delete();
    expect_seq(8'h00, 40);
    fetch_en = 1;
    out_ready = 1;
    chk("idle_no_issue", mem_read_en, 0);
    wait_valid("first_valid_lat", 8, 3);
    for (int i = 0; i < 9; i++) begin
      chk("stream_valid", out_valid, 1);
      tick();
    end
    // back-pressure fills the buffer
    rst_n = 0;
    exp_q.delete();
    out_ready = 0;
    tick();
    rst_n = 1;
    expect_seq(8'h00, 40);
    iss = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      iss += int'(mem_read_en);
    end
    chk("full_issue_cnt", iss, 3);
    chk("full_no_read", mem_read_en, 0);
    chk("full_valid", out_valid, 1);
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", out_valid, 1);
      tick();
    end
    // redirect with 2 buffered and 1 in flight
    rst_n = 0;
    exp_q.delete();
    fetch_en = 0;
    out_ready = 0;
    tick();
    rst_n = 1;
    expect_seq(8'h00, 40);
    fetch_en = 1;
    out_ready = 1;
    tick();
    tick();
    tick();
    tick();
    out_ready = 0;
    tick();
    chk("pre_redir_pc", mem_addr, 8'h04);
    chk("pre_redir_valid", out_valid, 1);
    redirect_valid = 1;
    redirect_pc = 8'h07;
    #1;
    chk("redir_no_issue", mem_read_en, 0);
    tick();
    redirect_valid = 0;
    exp_q.delete();
    expect_seq(8'h07, 40);
    out_ready = 1;
    chk("bubble_no_issue", mem_read_en, 0);
    chk("flushed_valid", out_valid, 0);
    tick();
    chk("target_issue", mem_read_en, 1);
    chk("target_addr", mem_addr, 8'h07);
    tick();
    chk("r3_valid", out_valid, 0);
    tick();
    chk("r4_valid", out_valid, 1);
    chk("r4_pc", out_pc, 8'h07);
    // redirect near the top of the address space
    tick();
    tick();
    redirect_valid = 1;
    redirect_pc = 8'hFE;
    tick();
    redirect_valid = 0;
    exp_q.delete();
    expect_seq(8'hFE, 40);
    h0 = hs;
    tick();
    tick();
    tick();
    chk("wrap_first_pc", out_pc, 8'hFE);
    for (int i = 0; i < 4; i++) tick();
    chk("wrap_cnt", hs - h0, 4);
    // asynchronous reset mid-stream
    rst_n = 0;
    #1;
    chk_reset_outs("mid_rst");
    exp_q.delete();
    tick();
    tick();
    rst_n = 1;
    expect_seq(8'h00, 40);
    wait_valid("post_rst_lat", 8, 3);
    chk("post_rst_pc", out_pc, 8'h00);
    // fetch_en low for 4 cycles
    tick();
    tick();
    fetch_en = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("en_low_no_issue", mem_read_en, 0);
    end
    fetch_en = 1;
    tick();
    chk("resume_issue", mem_read_en, 1);
    tick();
    tick();
    chk("resume_valid", out_valid, 1);
    for (int i = 0; i < 6; i++) tick();
    fetch_en = 0;
    for (int i = 0; i < 6; i++) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
